// File: rtl/cursor_config_ctrl_pkg.sv
// cursor_config_ctrl_pkg
// Shared definitions for the RTC display configuration path. The
// sequencer, the text generator and the RTC interface all import this
// package, so they agree on mode encodings and on field counts.
//   mode_e       : configuration mode encoding (0 normal .. 3 timer)
//   CUR_MAX_*    : highest cursor index in each configuration mode
//   cursor_max() : cursor limit for a given mode (0 in normal)
//   mode_after() : mode that follows a given mode when config is pressed
package cursor_config_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_HORA   = 2'd1,
    MODE_FECHA  = 2'd2,
    MODE_TIMER  = 2'd3
  } mode_e;

  // HORA fields: 0 = seconds, 1 = minutes, 2 = hours, 3 = AM/PM
  localparam logic [1:0] CUR_MAX_HORA  = 2'd3;
  // FECHA fields: 0 = year, 1 = month, 2 = day
  localparam logic [1:0] CUR_MAX_FECHA = 2'd2;
  localparam logic [1:0] CUR_MAX_TIMER = 2'd2;

  function automatic logic [1:0] cursor_max(input mode_e mode);
    case (mode)
      MODE_HORA:  return CUR_MAX_HORA;
      MODE_FECHA: return CUR_MAX_FECHA;
      MODE_TIMER: return CUR_MAX_TIMER;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic mode_e mode_after(input mode_e mode);
    case (mode)
      MODE_NORMAL: return MODE_HORA;
      MODE_HORA:   return MODE_FECHA;
      MODE_FECHA:  return MODE_TIMER;
      default:     return MODE_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/cursor_config_ctrl_if.sv
// cursor_config_ctrl_if
// Bundles the debounced button pulses going into the configuration
// sequencer and the registered control outputs coming out of it.
//   btn_config/left/right/up/down : single-cycle button pulses
//   config_mode, cursor_location  : current mode and selected field
//   parpadeo                      : cursor blink phase, 1 = drawn
//   inc_pulse, dec_pulse          : field adjust strobes to the RTC
//   commit_pulse, commit_target   : leave-mode strobe and old mode
// Modports: master drives buttons (debouncers / bench), slave is the
// sequencer itself.
interface cursor_config_ctrl_if;
  import cursor_config_ctrl_pkg::*;

  logic       btn_config;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  mode_e      config_mode;
  logic [1:0] cursor_location;
  logic       parpadeo;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       commit_pulse;
  mode_e      commit_target;

  modport master (
    output btn_config, btn_left, btn_right, btn_up, btn_down,
    input  config_mode, cursor_location, parpadeo,
           inc_pulse, dec_pulse, commit_pulse, commit_target
  );

  modport slave (
    input  btn_config, btn_left, btn_right, btn_up, btn_down,
    output config_mode, cursor_location, parpadeo,
           inc_pulse, dec_pulse, commit_pulse, commit_target
  );

endinterface

// File: rtl/cursor_config_ctrl_blink_timer.sv
// blink_timer
// Half-period toggler for the configuration cursor.
//   clk, reset : clock and synchronous active-high reset
//   enable     : low forces blink = 0 and holds the counter at 0
//   restart    : forces blink = 1 and restarts the half-period
//   blink      : registered blink phase
module blink_timer #(
  parameter int unsigned HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic blink
);

  localparam int unsigned W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] count;

  // The counter returns to 0 on the toggle, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
      blink <= 1'b0;
    end else if (restart) begin
      count <= '0;
      blink <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      blink <= ~blink;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cursor_config_ctrl.sv
// cursor_config_ctrl
// Turns debounced button pulses into the display configuration state.
// It produces the mode, the cursor field and the blink phase for the
// character generator, and the inc/dec/commit strobes for the RTC.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of cursor_config_ctrl_if (buttons in,
//                registered control outputs out)
// Parameters: BLINK_HALF = cycles per blink half-period,
//             IDLE_TIMEOUT = idle cycles before auto-exit with commit.
module cursor_config_ctrl
  import cursor_config_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_HALF   = 25_000_000,
  parameter int unsigned IDLE_TIMEOUT = 1_000_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  cursor_config_ctrl_if.slave  bus
);

  localparam int unsigned IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  mode_e         mode, mode_next;
  logic [1:0]    cursor, cursor_next;
  logic [IW-1:0] idle, idle_next;
  logic          inc, inc_next;
  logic          dec, dec_next;
  logic          commit, commit_next;
  mode_e         target, target_next;

  logic in_config;
  logic accept_config, accept_left, accept_right, accept_up, accept_down;
  logic any_accept;
  logic timeout;
  logic blink_enable;
  logic blink;

  // Only one button is taken per cycle (config > left > right > up >
  // down). Everything except config is dropped in normal mode.
  assign in_config     = (mode != MODE_NORMAL);
  assign accept_config = bus.btn_config;
  assign accept_left   = in_config && !bus.btn_config && bus.btn_left;
  assign accept_right  = in_config && !bus.btn_config && !bus.btn_left
                         && bus.btn_right;
  assign accept_up     = in_config && !bus.btn_config && !bus.btn_left
                         && !bus.btn_right && bus.btn_up;
  assign accept_down   = in_config && !bus.btn_config && !bus.btn_left
                         && !bus.btn_right && !bus.btn_up && bus.btn_down;
  assign any_accept    = accept_config || accept_left || accept_right
                         || accept_up || accept_down;
  assign timeout       = in_config && (idle == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode   <= MODE_NORMAL;
      cursor <= 2'd0;
      idle   <= '0;
      inc    <= 1'b0;
      dec    <= 1'b0;
      commit <= 1'b0;
      target <= MODE_NORMAL;
    end else begin
      mode   <= mode_next;
      cursor <= cursor_next;
      idle   <= idle_next;
      inc    <= inc_next;
      dec    <= dec_next;
      commit <= commit_next;
      target <= target_next;
    end
  end

  // An accepted button outranks a timeout in the same cycle, so a press
  // on the last idle cycle keeps the mode alive.
  always_comb begin
    mode_next   = mode;
    cursor_next = cursor;
    idle_next   = idle;
    inc_next    = 1'b0;
    dec_next    = 1'b0;
    commit_next = 1'b0;
    target_next = target;

    if (accept_config) begin
      mode_next = mode_after(mode);
      if (in_config) begin
        commit_next = 1'b1;
        target_next = mode;
      end
    end else if (accept_left) begin
      cursor_next = (cursor == cursor_max(mode)) ? 2'd0 : cursor + 2'd1;
    end else if (accept_right) begin
      cursor_next = (cursor == 2'd0) ? cursor_max(mode) : cursor - 2'd1;
    end else if (accept_up) begin
      inc_next = 1'b1;
    end else if (accept_down) begin
      dec_next = 1'b1;
    end else if (timeout) begin
      mode_next   = MODE_NORMAL;
      commit_next = 1'b1;
      target_next = mode;
    end

    if (mode_next != mode) begin
      cursor_next = 2'd0;
    end

    // timeout has already moved mode_next to NORMAL, so the increment
    // below never runs past IDLE_LAST.
    if (mode_next == MODE_NORMAL || any_accept) begin
      idle_next = '0;
    end else begin
      idle_next = idle + IW'(1);
    end
  end

  // Blink follows the next mode so parpadeo changes in step with
  // config_mode on the same edge.
  assign blink_enable = (mode_next != MODE_NORMAL);

  blink_timer #(
    .HALF(BLINK_HALF)
  ) u_blink_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (blink_enable),
    .restart (any_accept),
    .blink   (blink)
  );

  assign bus.config_mode     = mode;
  assign bus.cursor_location = cursor;
  assign bus.parpadeo        = blink;
  assign bus.inc_pulse       = inc;
  assign bus.dec_pulse       = dec;
  assign bus.commit_pulse    = commit;
  assign bus.commit_target   = target;

endmodule

// File: tb/tb_cursor_config_ctrl.sv
// tb_cursor_config_ctrl
// Scoreboard bench for cursor_config_ctrl with short blink and idle
// periods. The driver feeds each cycle's inputs into a reference model
// and queues the expected outputs; the monitor compares them after the
// following clock edge.
module tb_cursor_config_ctrl;
  import cursor_config_ctrl_pkg::*;

  localparam int BH = 4;
  localparam int IT = 20;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] cursor;
    logic       blink;
    logic       inc;
    logic       dec;
    logic       commit;
    logic [1:0] target;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference state: mode, cursor, last commit target, and the number of
  // quiet cycles since the last accepted button (drives blink and idle).
  int m_mode;
  int m_cursor;
  int m_quiet;
  int m_target;

  cursor_config_ctrl_if bus ();

  cursor_config_ctrl #(
    .BLINK_HALF   (BH),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit rst, input bit cfg, input bit l,
                            input bit r, input bit u, input bit d);
    exp_t e;
    int   mx;
    bit   accepted;
    e = '0;
    accepted = 0;
    if (rst) begin
      m_mode = 0;
      m_cursor = 0;
      m_quiet = 0;
      m_target = 0;
    end else begin
      mx = (m_mode == 1) ? 3 : 2;
      if (cfg) begin
        accepted = 1;
        if (m_mode != 0) begin
          e.commit = 1'b1;
          m_target = m_mode;
        end
        m_mode = (m_mode + 1) % 4;
        m_cursor = 0;
      end else if (m_mode != 0 && l) begin
        accepted = 1;
        m_cursor = (m_cursor + 1) % (mx + 1);
      end else if (m_mode != 0 && r) begin
        accepted = 1;
        m_cursor = (m_cursor + mx) % (mx + 1);
      end else if (m_mode != 0 && u) begin
        accepted = 1;
        e.inc = 1'b1;
      end else if (m_mode != 0 && d) begin
        accepted = 1;
        e.dec = 1'b1;
      end else if (m_mode != 0 && m_quiet + 1 == IT) begin
        e.commit = 1'b1;
        m_target = m_mode;
        m_mode = 0;
        m_cursor = 0;
      end else if (m_mode != 0) begin
        m_quiet = m_quiet + 1;
      end
      if (accepted || m_mode == 0) m_quiet = 0;
    end
    e.mode   = 2'(m_mode);
    e.cursor = 2'(m_cursor);
    e.blink  = (m_mode != 0) && (((m_quiet / BH) % 2) == 0);
    e.target = 2'(m_target);
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit rst, input bit cfg, input bit l,
                                input bit r, input bit u, input bit d);
    @(negedge clk);
    reset = rst;
    bus.btn_config = cfg;
    bus.btn_left = l;
    bus.btn_right = r;
    bus.btn_up = u;
    bus.btn_down = d;
    model_step(rst, cfg, l, r, u, d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_output(input exp_t e);
    exp_t a;
    bit   bad;
    a.mode   = bus.config_mode;
    a.cursor = bus.cursor_location;
    a.blink  = bus.parpadeo;
    a.inc    = bus.inc_pulse;
    a.dec    = bus.dec_pulse;
    a.commit = bus.commit_pulse;
    a.target = bus.commit_target;
    vectors++;
    bad = (a.mode !== e.mode) || (a.cursor !== e.cursor) ||
          (a.blink !== e.blink) || (a.inc !== e.inc) ||
          (a.dec !== e.dec) || (a.commit !== e.commit) ||
          (e.commit && (a.target !== e.target));
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL outputs vec=%0d got mode=%0d cur=%0d blink=%0b inc=%0b dec=%0b commit=%0b tgt=%0d expected mode=%0d cur=%0d blink=%0b inc=%0b dec=%0b commit=%0b tgt=%0d",
               vectors, a.mode, a.cursor, a.blink, a.inc, a.dec, a.commit,
               a.target, e.mode, e.cursor, e.blink, e.inc, e.dec, e.commit,
               e.target);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked #1 after the
  // edge that sampled it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    int density;
    vectors = 0;
    miscompares = 0;
    m_mode = 0;
    m_cursor = 0;
    m_quiet = 0;
    m_target = 0;
    reset = 1'b1;
    bus.btn_config = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;

    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);

    // Full mode cycle with commits on leaving each config mode
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 1, 0, 0, 0, 0);
      idle_cycles(1);
    end

    // HORA cursor wrap both ways, FECHA right-wrap from 0
    apply_stimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);

    // TIMER cursor 1 increment, then up/down ignored in NORMAL
    apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    idle_cycles(2);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    // Config and up together from NORMAL, then idle into the timeout
    apply_stimulus(0, 1, 0, 0, 1, 0);
    idle_cycles(25);

    // Press on the last idle cycle keeps HORA alive
    apply_stimulus(0, 1, 0, 0, 0, 0);
    idle_cycles(19);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    idle_cycles(6);

    // Reset mid-FECHA with cursor 2 aborts without commit
    apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle_cycles(2);

    // Random bursts with varying button density
    for (int b = 0; b < 30; b++) begin
      density = $urandom_range(2, 40);
      for (int i = 0; i < 60; i++) begin
        apply_stimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, density * 2) == 0,
                       $urandom_range(0, density - 1) == 0,
                       $urandom_range(0, density - 1) == 0,
                       $urandom_range(0, density - 1) == 0,
                       $urandom_range(0, density - 1) == 0);
      end
    end

    idle_cycles(1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
